alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer that shares one combinational 32-bit ALU between independent clients, such as the integer pipe and an address/branch-compare helper. It accepts operand/opcode requests over valid/ready handshakes and registers them into the ALU. It captures the result and flags one cycle later and returns them to the granted requester over a response handshake. It sits between the clients and the ALU instance; the ALU itself is untouched.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU (32).
- NREQ, 2, requester count; fixed at 2 in this revision.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: request i accepted this cycle.
- req_a  input  2*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  operand B, same packing.
- req_ctrl  input  6  3-bit ALU control per requester, slice [i*3 +: 3].
- resp_valid  output  2  bit i: result for requester i is available.
- resp_ready  input  2  bit i: requester i consumes the result.
- resp_result  output  WIDTH  result; valid only while a resp_valid bit is set.
- resp_flags  output  4  {Z,N,V,C} captured alongside the result.
- busy  output  1  high in EXEC and RESP.
- alu_a, alu_b  output  WIDTH  operands driven to the ALU.
- alu_ctrl  output  3  control driven to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_z, alu_n, alu_v, alu_c  input  1  ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is set, select grant g and assert req_ready[g] combinationally. Never assert both ready bits. Register a, b, ctrl and g, then go to EXEC.
- EXEC: drive alu_a, alu_b and alu_ctrl from registers. At the clock edge, register alu_result and the flags, then go to RESP.
- RESP: hold resp_valid[g]=1 and keep result and flags stable. When resp_ready[g]=1, go to IDLE. resp_valid is never asserted for the non-granted requester.
- Control codes are passed through unchanged: 000 add, 001 sub, 010 and, 011 or, 101 slt. Undefined codes return the ALU's output (zero), with no error.
- alu_* outputs hold the registered operands in every state. No glitching to request inputs.
- Arbitration: see Configuration.
- A requester that drops req_valid before req_ready is not served. No request state is kept.

## Timing
- Reset (rst=0 at edge): state IDLE; req_ready=0 except for the combinational IDLE grant; resp_valid=0, resp_result=0, resp_flags=0, busy=0, alu_a=alu_b=0, alu_ctrl=000; round-robin pointer favours requester 0.
- Reset mid-operation aborts without a response. Any captured operation is discarded.
- Accept at edge T. ALU evaluates during cycle T+1. resp_valid rises after edge T+1. Minimum accept-to-response latency is 2 cycles.
- With resp_ready held high, the minimum issue interval is 3 cycles per operation.
- req_ready is 0 in EXEC and RESP, so there is no pipelining and no back-to-back accept.
- If resp_ready is held low, RESP holds indefinitely and both requesters stall.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, grant goes to the requester not served last. The pointer updates only on accept.
- Not defined: fixed priority; requester 0 always wins on a simultaneous request. The pointer register is not generated.

## Structure
- Package alu_arb_pkg: state enum (IDLE, EXEC, RESP), ALU control constants (ADD, SUB, AND, OR, SLT), and the flag bit positions for Z, N, V and C.
- Sub-module rr_arb2 (2-way grant picker with last-grant pointer) handles arbitration. Its grant comes out combinationally from req_valid and the pointer.

## Test plan
- Single add: req0 a=5, b=7, ctrl=000 → accepted at T, resp_valid[0] after T+1, result=12, flags=0000.
- Sub overflow: req1 a=0x80000000, b=1, ctrl=001 → result=0x7FFFFFFF, V=1, C=1, N=0, Z=0.
- Contention, 4 back-to-back rounds with both valid: RR_EN build → grants alternate 0,1,0,1; without the macro → grant 0 every round.
- Backpressure: resp_ready[0] held low 5 cycles → result and flags stable, req_ready=0 throughout, busy=1.
- Reset in EXEC: rst low one edge → IDLE, no resp_valid, all outputs zero next cycle.
- slt and zero: a=3, b=9, ctrl=101 → result=1; a=b=0x1234, ctrl=001 → result=0, Z=1, C=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the alu_arbiter slice.
// FSM state encoding, ALU control codes and the {Z,N,V,C} flag bit positions.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic v, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant picker. Round-robin with a last-grant pointer when ALU_ARB_RR_EN
// is defined, otherwise fixed priority with requester 0 winning.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

`ifdef ALU_ARB_RR_EN
  logic r_last;

  // Reset value 1 makes requester 0 the first winner on contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_idx;
    end
  end

  always_comb begin
    o_idx = 1'b0;
    if (i_req == 2'b11) begin
      o_idx = ~r_last;
    end else if (i_req[1] && !i_req[0]) begin
      o_idx = 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, i_accept};

  always_comb begin
    o_idx = i_req[1] && !i_req[0];
  end
`endif

  always_comb begin
    o_gnt = '0;
    if (|i_req) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, execute,
// respond. Build option ALU_ARB_RR_EN selects round-robin instead of fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*3-1:0]       req_ctrl,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]        resp_result,
  output logic [3:0]              resp_flags,
  output logic                    busy,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [2:0]              alu_ctrl,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic                    alu_z,
  input  logic                    alu_n,
  input  logic                    alu_v,
  input  logic                    alu_c
);

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_ctrl;
  logic               r_g;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;

  logic [NREQ-1:0]    w_gnt;
  logic               w_gnt_idx;
  logic               w_accept;
  logic               w_resp_done;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [2:0]         w_sel_ctrl;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_idx    (w_gnt_idx)
  );

  assign w_accept    = (r_state == IDLE) && (|req_valid);
  assign w_resp_done = (r_state == RESP) && resp_ready[r_g];

  assign w_sel_a    = w_gnt_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
  assign w_sel_b    = w_gnt_idx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
  assign w_sel_ctrl = w_gnt_idx ? req_ctrl[3 +: 3]      : req_ctrl[0 +: 3];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)    w_next = EXEC;
      EXEC:                     w_next = RESP;
      RESP:    if (w_resp_done) w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = 1'b0;
    unique case (r_state)
      IDLE: req_ready = w_gnt;
      EXEC: busy      = 1'b1;
      RESP: begin
        busy            = 1'b1;
        resp_valid[r_g] = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands stay registered across all states so the ALU inputs never follow request inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= '0;
      r_g      <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= w_sel_a;
        r_b    <= w_sel_b;
        r_ctrl <= w_sel_ctrl;
        r_g    <= w_gnt_idx;
      end
      if (r_state == EXEC) begin
        r_result <= alu_result;
        r_flags  <= pack_flags(alu_z, alu_n, alu_v, alu_c);
      end
    end
  end

  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_ctrl    = r_ctrl;
  assign resp_result = r_result;
  assign resp_flags  = r_flags;

endmodule
